// File: rtl/uart_rx_buffered.sv
// UART receiver (start, 8 data LSB-first, optional even parity, 1 stop) feeding a DEPTH-entry FWFT buffer.
// Define UART_RX_PARITY_EN to receive and check the even-parity bit; otherwise PARITY_RX reads 1.
module uart_rx_buffered #(
  parameter int DEPTH = 4,
  parameter int WFR_W = 12
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             RX,
  input  logic [WFR_W-1:0] WORK_FR,
  input  logic             RD_EN,
  output logic [7:0]       DATA_RX,
  output logic             PARITY_RX,
  output logic             VALID,
  output logic             BUSY,
  output logic             FRAME_ERR,
  output logic             OVERRUN
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] ST_PARITY = 3'd3;
`endif
  localparam logic [2:0] ST_STOP   = 3'd4;

`ifdef UART_RX_PARITY_EN
  function automatic logic even_par_ok(input logic [7:0] data, input logic par_bit);
    even_par_ok = ~(^{data, par_bit});
  endfunction
`endif

  logic             r_sync1;
  logic             r_sync2;
  logic             r_rx_prev;
  logic [2:0]       r_state;
  logic [WFR_W-1:0] r_cnt;
  logic [WFR_W-1:0] r_wfr;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_shift;
`ifdef UART_RX_PARITY_EN
  logic             r_par_ok;
`endif
  logic [8:0]       r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [7:0]       r_data_out;
  logic             r_par_out;
  logic             r_frame_err;
  logic             r_overrun;

  logic             w_fall;
  logic             w_bit_tick;
  logic             w_half_tick;
  logic             w_push;
  logic             w_ferr;
  logic             w_pop;
  logic             w_full;
  logic             w_wr;
  logic             w_ovr;
  logic [8:0]       w_word;
  logic [PTR_W-1:0] w_rd_next;

  assign w_fall      = r_rx_prev & ~r_sync2;
  assign w_bit_tick  = (r_cnt == (r_wfr - WFR_W'(1)));
  assign w_half_tick = (r_cnt == (r_wfr >> 1));
`ifdef UART_RX_PARITY_EN
  assign w_word      = {r_par_ok, r_shift};
`else
  assign w_word      = {1'b1, r_shift};
`endif
  assign w_pop       = RD_EN && (r_count != CNT_W'(0));
  assign w_full      = (r_count == CNT_W'(DEPTH));
  assign w_wr        = w_push && (!w_full || w_pop);
  assign w_ovr       = w_push && w_full && !w_pop;
  assign w_rd_next   = r_rd_ptr + PTR_W'(1);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_sync1   <= RX;
      r_sync2   <= r_sync1;
      r_rx_prev <= r_sync2;
    end
  end

  // The stop sample either delivers the byte or flags a framing error.
  always_comb begin
    w_push = 1'b0;
    w_ferr = 1'b0;
    if ((r_state == ST_STOP) && w_bit_tick) begin
      w_push = r_sync2;
      w_ferr = ~r_sync2;
    end else begin
      w_push = 1'b0;
      w_ferr = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state   <= ST_IDLE;
      r_cnt     <= {WFR_W{1'b0}};
      r_wfr     <= {WFR_W{1'b0}};
      r_bit_idx <= 3'd0;
      r_shift   <= 8'd0;
`ifdef UART_RX_PARITY_EN
      r_par_ok  <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_cnt     <= {WFR_W{1'b0}};
          r_bit_idx <= 3'd0;
          r_wfr     <= WORK_FR;
          if (w_fall) r_state <= ST_START;
        end
        ST_START: begin
          // A line back high at mid start bit is a glitch, not a frame.
          if (w_half_tick) begin
            r_cnt   <= {WFR_W{1'b0}};
            r_state <= r_sync2 ? ST_IDLE : ST_DATA;
          end else begin
            r_cnt <= r_cnt + WFR_W'(1);
          end
        end
        ST_DATA: begin
          if (w_bit_tick) begin
            r_cnt     <= {WFR_W{1'b0}};
            r_shift   <= {r_sync2, r_shift[7:1]};
            r_bit_idx <= r_bit_idx + 3'd1;
            if (r_bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              r_state <= ST_PARITY;
`else
              r_state <= ST_STOP;
`endif
            end
          end else begin
            r_cnt <= r_cnt + WFR_W'(1);
          end
        end
`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (w_bit_tick) begin
            r_cnt    <= {WFR_W{1'b0}};
            r_par_ok <= even_par_ok(r_shift, r_sync2);
            r_state  <= ST_STOP;
          end else begin
            r_cnt <= r_cnt + WFR_W'(1);
          end
        end
`endif
        ST_STOP: begin
          if (w_bit_tick) begin
            r_cnt   <= {WFR_W{1'b0}};
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + WFR_W'(1);
          end
        end
        default: begin
          r_cnt   <= {WFR_W{1'b0}};
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (w_wr) r_mem[r_wr_ptr] <= w_word;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_wr_ptr    <= {PTR_W{1'b0}};
      r_rd_ptr    <= {PTR_W{1'b0}};
      r_count     <= {CNT_W{1'b0}};
      r_data_out  <= 8'd0;
      r_par_out   <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_frame_err <= w_ferr;
      r_overrun   <= w_ovr;
      if (w_wr) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop) r_rd_ptr <= w_rd_next;
      if (w_wr && !w_pop) r_count <= r_count + CNT_W'(1);
      else if (w_pop && !w_wr) r_count <= r_count - CNT_W'(1);
      // Head register: the incoming word becomes head when the buffer is (or is about to be) empty.
      if (w_wr && ((r_count == CNT_W'(0)) || (w_pop && (r_count == CNT_W'(1))))) begin
        r_data_out <= w_word[7:0];
        r_par_out  <= w_word[8];
      end else if (w_pop && (r_count > CNT_W'(1))) begin
        r_data_out <= r_mem[w_rd_next][7:0];
        r_par_out  <= r_mem[w_rd_next][8];
      end
    end
  end

  assign DATA_RX   = r_data_out;
  assign PARITY_RX = r_par_out;
  assign VALID     = (r_count != CNT_W'(0));
  assign BUSY      = (r_state != ST_IDLE);
  assign FRAME_ERR = r_frame_err;
  assign OVERRUN   = r_overrun;

endmodule

// File: tb/tb_uart_rx_buffered.sv
// Self-checking bench for uart_rx_buffered: directed scenarios plus randomized frames
// checked against a frame-level queue model of the receive buffer.
module tb_uart_rx_buffered;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx;
  logic        rd_en;
  logic [11:0] work_fr;
  logic [7:0]  data_rx;
  logic        parity_rx, valid, busy, frame_err, overrun;

  uart_rx_buffered #(.DEPTH(DEPTH), .WFR_W(12)) dut (
    .CLK(clk), .RESET(rst), .RX(rx), .WORK_FR(work_fr), .RD_EN(rd_en),
    .DATA_RX(data_rx), .PARITY_RX(parity_rx), .VALID(valid), .BUSY(busy),
    .FRAME_ERR(frame_err), .OVERRUN(overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0, fe_cnt = 0, ov_cnt = 0, long_cnt = 0, busy_cnt = 0, v_rise = -1;
  logic fe_prev = 1'b0, ov_prev = 1'b0, v_prev = 1'b0;
  int wfr = 16, t0 = 0, last_nb = 10, exp_fe = 0, exp_ovr = 0;
  logic [8:0] q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse/event monitor sampled mid-cycle.
  always @(negedge clk) begin
    fe_prev <= frame_err;
    ov_prev <= overrun;
    v_prev  <= valid;
    if (frame_err === 1'b1) fe_cnt <= fe_cnt + 1;
    if (overrun === 1'b1) ov_cnt <= ov_cnt + 1;
    if ((frame_err === 1'b1 && fe_prev) || (overrun === 1'b1 && ov_prev)) long_cnt <= long_cnt + 1;
    if (valid === 1'b1 && !v_prev) v_rise <= cyc;
    if (busy === 1'b1) busy_cnt <= busy_cnt + 1;
  end

  task automatic idle(input int n);
    rx = 1'b1;
    rd_en = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Drives one frame bit-by-bit; optionally pops at cycle pop_at; updates the model at the end.
  task automatic send_frame(input logic [7:0] b, input logic par, input logic stp,
                            input int pop_at, input logic scramble);
    logic [10:0] fr;
    logic        pok;
    logic [8:0]  e;
    int          nb;
`ifdef UART_RX_PARITY_EN
    nb = 11; fr = {stp, par, b, 1'b0}; pok = ~(^{b, par});
`else
    nb = 10; fr = {1'b0, stp, b, 1'b0}; pok = 1'b1;
`endif
    last_nb = nb;
    t0 = cyc;
    for (int c = 0; c < nb * wfr; c++) begin
      int bi;
      bi = c / wfr;
      rx = fr[bi];
      if (scramble && bi >= 1 && bi <= 8) work_fr = 12'($urandom_range(4, 60));
      else work_fr = 12'(wfr);
      if (c == pop_at) begin
        e = (q.size() > 0) ? q[0] : 9'h0;
        checks++;
        if (valid !== 1'b1 || data_rx !== e[7:0]) begin
          failures++;
          $display("FAIL pop_at_push: got valid=%b data=%02h expected valid=1 data=%02h", valid, data_rx, e[7:0]);
        end
        rd_en = 1'b1;
        if (q.size() > 0) void'(q.pop_front());
      end else begin
        rd_en = 1'b0;
      end
      @(negedge clk);
    end
    rx = 1'b1;
    rd_en = 1'b0;
    work_fr = 12'(wfr);
    if (!stp) exp_fe++;
    else if (q.size() < DEPTH) q.push_back({pok, b});
    else exp_ovr++;
  endtask

  task automatic pop_check(input string name);
    logic [8:0] e;
    e = (q.size() > 0) ? q[0] : 9'h0;
    checks++;
    if (valid !== 1'b1 || data_rx !== e[7:0] || parity_rx !== e[8]) begin
      failures++;
      $display("FAIL %s: got valid=%b data=%02h par=%b expected valid=1 data=%02h par=%b",
               name, valid, data_rx, parity_rx, e[7:0], e[8]);
    end
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    if (q.size() > 0) void'(q.pop_front());
  endtask

  task automatic drain_check(input string name);
    while (q.size() > 0) pop_check(name);
    checks++;
    if (valid !== 1'b0) begin
      failures++;
      $display("FAIL %s_empty: got valid=%b expected 0", name, valid);
    end
  endtask

  task automatic check_events(input string name);
    checks++;
    if (fe_cnt !== exp_fe || ov_cnt !== exp_ovr || long_cnt !== 0) begin
      failures++;
      $display("FAIL %s_events: got fe=%0d ovr=%0d long=%0d expected fe=%0d ovr=%0d long=0",
               name, fe_cnt, ov_cnt, long_cnt, exp_fe, exp_ovr);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; rx = 1'b1; rd_en = 1'b0; wfr = 16; work_fr = 12'd16;
    repeat (3) @(negedge clk);
    checks++;
    if (valid !== 1'b0 || busy !== 1'b0 || data_rx !== 8'h00 || parity_rx !== 1'b0 ||
        frame_err !== 1'b0 || overrun !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: got v=%b b=%b d=%02h p=%b fe=%b ov=%b expected all 0",
               valid, busy, data_rx, parity_rx, frame_err, overrun);
    end
    rst = 1'b0;
    idle(5);
    checks++;
    if (valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle: got valid=%b busy=%b expected 0 0", valid, busy);
    end
  endtask

  task automatic test_basic();
    wfr = 16;
    send_frame(8'hAA, 1'b0, 1'b1, -1, 1'b0);
    idle(4);
    checks++;
    if (v_rise - t0 !== 4 + wfr / 2 + wfr * (last_nb - 1)) begin
      failures++;
      $display("FAIL valid_latency: got %0d expected %0d", v_rise - t0, 4 + wfr / 2 + wfr * (last_nb - 1));
    end
    drain_check("basic");
    check_events("basic");
  endtask

  task automatic test_parity_err();
    wfr = 16;
    send_frame(8'h01, 1'b0, 1'b1, -1, 1'b0);
    idle(4);
    drain_check("parity");
  endtask

  task automatic test_frame_err();
    wfr = 16;
    send_frame(8'h55, 1'b0, 1'b0, -1, 1'b0);
    idle(6);
    checks++;
    if (valid !== 1'b0) begin
      failures++;
      $display("FAIL frame_err_valid: got %b expected 0", valid);
    end
    check_events("frame_err");
    send_frame(8'h3C, 1'b0, 1'b1, -1, 1'b0);
    idle(4);
    drain_check("after_ferr");
    check_events("after_ferr");
  endtask

  task automatic test_overrun();
    wfr = 16;
    for (int i = 0; i < 5; i++) send_frame(8'h10 + 8'(i), ^(8'h10 + 8'(i)), 1'b1, -1, 1'b0);
    idle(4);
    check_events("overrun");
    drain_check("overrun");
  endtask

  task automatic test_full_pushpop();
    wfr = 16;
    for (int i = 0; i < 4; i++) send_frame(8'hA0 + 8'(i), 1'b0, 1'b1, -1, 1'b0);
    idle(4);
    send_frame(8'hA4, 1'b1, 1'b1, 3 + wfr / 2 + wfr * (last_nb - 1), 1'b0);
    idle(4);
    check_events("full_pushpop");
    drain_check("full_pushpop");
  endtask

  task automatic test_count1();
    wfr = 16;
    send_frame(8'hB0, 1'b1, 1'b1, -1, 1'b0);
    idle(4);
    send_frame(8'hB1, 1'b0, 1'b1, 3 + wfr / 2 + wfr * (last_nb - 1), 1'b0);
    idle(4);
    checks++;
    if (q.size() !== 1) begin
      failures++;
      $display("FAIL count1_model: got %0d entries expected 1", q.size());
    end
    drain_check("count1");
  endtask

  task automatic test_glitch();
    int base;
    wfr = 16;
    base = busy_cnt;
    rx = 1'b0;
    repeat (2) @(negedge clk);
    idle(24);
    checks++;
    if (busy_cnt - base !== wfr / 2 + 1) begin
      failures++;
      $display("FAIL glitch_busy: got %0d busy cycles expected %0d", busy_cnt - base, wfr / 2 + 1);
    end
    checks++;
    if (valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL glitch_state: got valid=%b busy=%b expected 0 0", valid, busy);
    end
    check_events("glitch");
  endtask

  task automatic test_reset_midframe();
    logic [9:0] fr;
    wfr = 16;
    work_fr = 12'(wfr);
    fr = {1'b1, 8'hC3, 1'b0};
    for (int c = 0; c < 5 * wfr + wfr / 2; c++) begin
      rx = fr[c / wfr];
      @(negedge clk);
    end
    rst = 1'b1;
    rx = 1'b1;
    @(negedge clk);
    checks++;
    if (valid !== 1'b0 || busy !== 1'b0 || data_rx !== 8'h00 || parity_rx !== 1'b0 ||
        frame_err !== 1'b0 || overrun !== 1'b0) begin
      failures++;
      $display("FAIL midframe_reset: got v=%b b=%b d=%02h p=%b fe=%b ov=%b expected all 0",
               valid, busy, data_rx, parity_rx, frame_err, overrun);
    end
    rst = 1'b0;
    q.delete();
    idle(8);
    send_frame(8'hC3, 1'b0, 1'b1, -1, 1'b0);
    idle(4);
    drain_check("after_reset");
    check_events("after_reset");
  endtask

  task automatic test_random();
    logic [7:0] b;
    logic       par, stp;
    for (int n = 0; n < 24; n++) begin
      wfr = $urandom_range(4, 12);
      b = 8'($urandom);
      par = 1'($urandom);
      stp = ($urandom_range(0, 7) != 0);
      send_frame(b, par, stp, -1, 1'b1);
      if (!stp || $urandom_range(0, 2) != 0) begin
        idle(3);
        if (q.size() > 0 && $urandom_range(0, 1) == 1) pop_check("rand_pop");
        idle($urandom_range(0, 20));
      end
    end
    idle(4);
    check_events("random");
    drain_check("random");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity_err();
    test_frame_err();
    test_overrun();
    test_full_pushpop();
    test_count1();
    test_glitch();
    test_reset_midframe();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx_buffered.md
# uart_rx_buffered

Stand-alone UART receiver with a small first-word-fall-through (FWFT) receive buffer. It pairs with the transmit side of the existing `UART` block. It shares that block's per-bit clock-count scheme (`WORK_FR`) and its even-parity framing. It sits between the RX pin and a consumer that drains bytes at its own pace, and it reports framing and overrun errors the bare UART cannot.

## Interface
Parameters:
- `DEPTH`, 4: buffer entries; power of two, 2..16.
- `WFR_W`, 12: width of `WORK_FR`.

Ports:
- `CLK`, in, 1: single clock for all logic.
- `RESET`, in, 1: synchronous, active-high reset.
- `RX`, in, 1: asynchronous serial line; idles high.
- `WORK_FR`, in, `WFR_W`: clock cycles per bit (CLOCK_FREQ/BAUD_RATE); must be ≥ 4.
- `RD_EN`, in, 1: consumer pop request.
- `DATA_RX`, out, 8: head-of-buffer byte.
- `PARITY_RX`, out, 1: head-of-buffer parity-OK flag (1 = even parity matched).
- `VALID`, out, 1: buffer non-empty; `DATA_RX`/`PARITY_RX` are meaningful.
- `BUSY`, out, 1: receiver FSM is not in IDLE.
- `FRAME_ERR`, out, 1: one-cycle pulse; stop bit was sampled low.
- `OVERRUN`, out, 1: one-cycle pulse; good frame dropped because the buffer was full.

## Operation
- `RX` passes through a 2-FF synchronizer (reset value 1), followed by one history FF for falling-edge detection.
- FSM states: IDLE, START, DATA, PARITY (only with the macro defined), STOP.
- IDLE:
  - A synchronized falling edge goes to START.
  - The bit counter clears.
  - `WORK_FR` is latched into `wfr_q` for the whole frame.
- START:
  - At counter == `wfr_q>>1` (mid start bit), sample the line.
  - Line low: go to DATA and clear the counter.
  - Line high: treat as a glitch and return to IDLE; no error.
- DATA:
  - Counter counts 0..`wfr_q`-1; each wrap (counter == `wfr_q`-1) is one mid-bit sample.
  - 8 samples are shifted in LSB-first, then go to PARITY (or STOP).
- PARITY:
  - One sample; `par_ok = ^{data, sample} == 0` (even).
- STOP:
  - One sample.
  - Sample = 1: push `{par_ok, data}` into the buffer.
  - Sample = 0: pulse `FRAME_ERR` and discard the byte.
  - Either way, return to IDLE. A new frame needs a fresh falling edge, so a held-low break produces exactly one `FRAME_ERR`.
- Buffer:
  - Circular, with `DEPTH` entries and rd/wr pointers plus a count of width clog2(`DEPTH`)+1.
  - Pop occurs when `RD_EN && VALID`. `RD_EN` while empty is ignored.
- Full buffer:
  - Push while full and no pop in the same cycle: byte dropped, `OVERRUN` pulses, buffer contents unchanged.
  - Push and pop in the same cycle while full: both happen, no overrun.
- Push and pop in the same cycle while count is 1: the count stays 1 and the new byte becomes head.

## Timing
- Reset values:
  - `DATA_RX` = 0, `PARITY_RX` = 0, `VALID` = 0, `BUSY` = 0, `FRAME_ERR` = 0, `OVERRUN` = 0.
  - FSM in IDLE, buffer empty, synchronizer at 1.
- Reset asserted mid-frame aborts the frame with no error pulse. The partial byte is lost.
- Start detection: 3 `CLK` after the line edge (2 sync stages + edge FF).
- `BUSY` rises the cycle after the edge is detected and falls the cycle after the stop sample.
- `VALID` rises 1 `CLK` after the stop-sample cycle.
- `FRAME_ERR` and `OVERRUN` assert on that same cycle, for exactly 1 cycle.
- FWFT: `DATA_RX`/`PARITY_RX` are registered and change only on the cycle after a push-to-empty or a pop.
- Sample points after the start edge: `wfr_q>>1`, then every `wfr_q` cycles.
- Throughput: back-to-back frames with a single stop bit are received without loss, since the FSM re-arms in IDLE before the next start edge.
- Changing `WORK_FR` mid-frame has no effect until the next frame.

## Configuration
- Macro: `UART_RX_PARITY_EN`.
- Defined:
  - Frame is 11 bits: start + 8 data + even parity + stop.
  - `PARITY_RX` carries the check result.
- Undefined:
  - Frame is 10 bits: start + 8 data + stop; the PARITY state is not built.
  - `PARITY_RX` is tied to 1 in every buffer entry.

## Test plan
- Reset, `WORK_FR`=16, macro defined: drive frame 0xAA with parity 0 and stop 1, `RD_EN`=0 -> `VALID`=1, `DATA_RX`=0xAA, `PARITY_RX`=1. Pulse `RD_EN` -> `VALID`=0 the next cycle.
- Same setup, frame 0x01 with parity bit 0 (wrong) -> `DATA_RX`=0x01, `PARITY_RX`=0.
- Frame 0x55 with stop bit 0 -> one `FRAME_ERR` pulse, `VALID` stays 0. A following good 0x3C is received normally.
- `DEPTH`=4, 5 back-to-back frames 0x10..0x14 with no reads -> `OVERRUN` pulses once on 0x14. Draining returns 0x10, 0x11, 0x12, 0x13, then `VALID`=0.
- 2-cycle low glitch on `RX` in idle -> `BUSY` pulses, then returns to IDLE. No `FRAME_ERR`, `VALID`=0.
- Assert `RESET` during data bit 4 of a frame -> all outputs 0 the next cycle. The next full frame 0xC3 is received correctly.
